dense_layer_seq: RTL and testbench

DENSE_LAYER_SEQ -- requirements
Module: dense_layer_seq

---
 rtl/dense_layer_seq_if.sv | 30 +++
 rtl/dense_layer_seq.sv | 162 ++++++++++++++++
 tb/tb_dense_layer_seq.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dense_layer_seq_if.sv
// Host-side bus of the dense layer sequencer: run control, input vector,
// coefficient write port and the layer results.
interface dense_layer_seq_if #(
   parameter int N           = 16,
   parameter int NUM_INPUTS  = 2,
   parameter int NUM_NEURONS = 1
);
   localparam int NC = NUM_NEURONS * (NUM_INPUTS + 1);
   localparam int AW = (NC > 1) ? $clog2(NC) : 1;

   logic                        fire;
   logic [NUM_INPUTS*N-1:0]     data_in;
   logic                        cfg_we;
   logic [AW-1:0]               cfg_addr;
   logic [N-1:0]                cfg_wdata;
   logic [NUM_NEURONS*N-1:0]    data_out;
   logic                        done;
   logic                        busy;
   logic                        overflow;

   modport master (
      output fire, data_in, cfg_we, cfg_addr, cfg_wdata,
      input  data_out, done, busy, overflow
   );

   modport slave (
      input  fire, data_in, cfg_we, cfg_addr, cfg_wdata,
      output data_out, done, busy, overflow
   );
endinterface

// File: rtl/dense_layer_seq.sv
// Sequential fully-connected layer: one shared N x N multiplier and one
// accumulator walk every weight of every neuron, then saturate the Q-format
// result into the neuron's output slot.
// Optional ReLU on the saturated result: define DENSE_LAYER_RELU_EN.
//
// state | meaning
// IDLE  | waiting for fire; coefficient writes accepted
// MAC   | acc += x[i] * w[j][i], one input per cycle
// WB    | shift, clamp (and ReLU) acc into data_out slot j; load next bias
// DONE  | one-cycle done pulse, busy still high
module dense_layer_seq #(
   parameter int N           = 16,
   parameter int Q           = 13,
   parameter int NUM_INPUTS  = 2,
   parameter int NUM_NEURONS = 1
) (
   input  logic               clk,
   input  logic               rstn,
   dense_layer_seq_if.slave   bus
);
   localparam int NI   = NUM_INPUTS;
   localparam int NO   = NUM_NEURONS;
   localparam int NC   = NO * (NI + 1);
   localparam int AW   = (NC > 1) ? $clog2(NC) : 1;
   localparam int IW   = (NI > 1) ? $clog2(NI) : 1;
   localparam int JW   = (NO > 1) ? $clog2(NO) : 1;
   localparam int ACCW = 2 * N + $clog2(NI + 1);

   localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-N+1){1'b1}}, {(N-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

   state_t                  state;
   logic [IW-1:0]           i_cnt;
   logic [JW-1:0]           j_cnt;
   logic signed [ACCW-1:0]  acc;
   logic signed [N-1:0]     x_reg [NI];
   logic signed [N-1:0]     coef  [NC];
   logic [NO*N-1:0]         data_out_r;
   logic                    done_r;
   logic                    busy_r;
   logic                    ovf_r;

   logic                    cfg_hit;
   logic [AW-1:0]           w_idx;
   logic [AW-1:0]           nb_idx;
   logic signed [N-1:0]     x_cur;
   logic signed [N-1:0]     w_cur;
   logic signed [N-1:0]     b_first;
   logic signed [N-1:0]     b_next;
   logic signed [2*N-1:0]   prod;
   logic signed [ACCW-1:0]  r_full;
   logic signed [N-1:0]     r_sat;
   logic signed [N-1:0]     r_act;
   logic                    sat;

   // Bias in Q format, sign-extended to accumulator width.
   function automatic logic signed [ACCW-1:0] bias_to_acc(input logic signed [N-1:0] b);
      return ACCW'(b) <<< Q;
   endfunction

   // Coefficient addressing, multiplier operand selection and write-back math.
   always_comb begin
      cfg_hit = bus.cfg_we && !busy_r && ((AW+1)'(bus.cfg_addr) < (AW+1)'(NC));
      w_idx   = AW'(j_cnt) * AW'(NI + 1) + AW'(i_cnt);
      // Only consumed when another neuron follows, so it is always in range then.
      nb_idx  = (AW'(j_cnt) + AW'(1)) * AW'(NI + 1) + AW'(NI);
      x_cur   = x_reg[i_cnt];
      w_cur   = coef[w_idx];
      b_next  = coef[nb_idx];
      // A write landing on the same edge as fire must already feed the first bias.
      b_first = (cfg_hit && (bus.cfg_addr == AW'(NI))) ? bus.cfg_wdata : coef[NI];
      prod    = (2*N)'(x_cur) * (2*N)'(w_cur);
      r_full  = acc >>> Q;
      sat     = 1'b0;
      r_sat   = r_full[N-1:0];
      if (r_full > SAT_MAX) begin
         r_sat = {1'b0, {(N-1){1'b1}}};
         sat   = 1'b1;
      end else if (r_full < SAT_MIN) begin
         r_sat = {1'b1, {(N-1){1'b0}}};
         sat   = 1'b1;
      end
`ifdef DENSE_LAYER_RELU_EN
      r_act = r_sat[N-1] ? '0 : r_sat;
`else
      r_act = r_sat;
`endif
   end

   // Coefficient store: writes land only while idle and inside the table.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NC; k++) coef[k] <= '0;
      end else if (cfg_hit) begin
         coef[bus.cfg_addr] <= bus.cfg_wdata;
      end
   end

   // Sequencer: state, counters, accumulator and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= S_IDLE;
         i_cnt      <= '0;
         j_cnt      <= '0;
         acc        <= '0;
         data_out_r <= '0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
         ovf_r      <= 1'b0;
         for (int k = 0; k < NI; k++) x_reg[k] <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.fire) begin
                  for (int k = 0; k < NI; k++) x_reg[k] <= bus.data_in[k*N +: N];
                  i_cnt  <= '0;
                  j_cnt  <= '0;
                  acc    <= bias_to_acc(b_first);
                  ovf_r  <= 1'b0;
                  busy_r <= 1'b1;
                  state  <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc + ACCW'(prod);
               if (i_cnt == IW'(NI - 1)) begin
                  i_cnt <= '0;
                  state <= S_WB;
               end else begin
                  i_cnt <= i_cnt + 1'b1;
               end
            end
            S_WB: begin
               data_out_r[j_cnt*N +: N] <= r_act;
               if (sat) ovf_r <= 1'b1;
               if (j_cnt == JW'(NO - 1)) begin
                  done_r <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  j_cnt <= j_cnt + 1'b1;
                  i_cnt <= '0;
                  acc   <= bias_to_acc(b_next);
                  state <= S_MAC;
               end
            end
            S_DONE: begin
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.data_out = data_out_r;
   assign bus.done     = done_r;
   assign bus.busy     = busy_r;
   assign bus.overflow = ovf_r;
endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: a default 2-input/1-neuron instance and a
// 3-input/2-neuron instance, with a reference model feeding a scoreboard.
module tb_dense_layer_seq;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   dense_layer_seq_if #(.N(16), .NUM_INPUTS(2), .NUM_NEURONS(1)) a_if();
   dense_layer_seq_if #(.N(16), .NUM_INPUTS(3), .NUM_NEURONS(2)) b_if();

   dense_layer_seq #(.N(16), .Q(13), .NUM_INPUTS(2), .NUM_NEURONS(1)) dut_a (
      .clk(clk), .rstn(rstn), .bus(a_if.slave));
   dense_layer_seq #(.N(16), .Q(13), .NUM_INPUTS(3), .NUM_NEURONS(2)) dut_b (
      .clk(clk), .rstn(rstn), .bus(b_if.slave));

   int n_vec  = 0;
   int n_miss = 0;
   logic [15:0] sh_a [3];
   logic [15:0] sh_b [8];
   logic [16:0] q_a [$];
   logic [32:0] q_b [$];

   // Reference neuron: {overflow, result}.
   function automatic logic [16:0] model(input logic [15:0] xs[4], input logic [15:0] ws[4],
                                         input logic [15:0] b, input int ni);
      longint acc, r;
      logic ovf;
      logic [15:0] y;
      acc = longint'($signed(b)) * 64'sd8192;
      for (int k = 0; k < ni; k++) acc += longint'($signed(xs[k])) * longint'($signed(ws[k]));
      r = acc >>> 13;
      ovf = 1'b0;
      if (r > 64'sd32767) begin r = 64'sd32767; ovf = 1'b1; end
      else if (r < -64'sd32768) begin r = -64'sd32768; ovf = 1'b1; end
      y = r[15:0];
`ifdef DENSE_LAYER_RELU_EN
      if (r < 0) y = 16'h0;
`endif
      return {ovf, y};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_if.fire = 1'b0; a_if.cfg_we = 1'b0; a_if.cfg_addr = '0; a_if.cfg_wdata = '0; a_if.data_in = '0;
      b_if.fire = 1'b0; b_if.cfg_we = 1'b0; b_if.cfg_addr = '0; b_if.cfg_wdata = '0; b_if.data_in = '0;
   endtask

   task automatic cfg_a(input logic [1:0] ad, input logic [15:0] d);
      a_if.cfg_we = 1'b1; a_if.cfg_addr = ad; a_if.cfg_wdata = d;
      tick();
      a_if.cfg_we = 1'b0;
      if (ad < 2'd3) sh_a[ad] = d;
   endtask

   task automatic cfg_b(input logic [2:0] ad, input logic [15:0] d);
      b_if.cfg_we = 1'b1; b_if.cfg_addr = ad; b_if.cfg_wdata = d;
      tick();
      b_if.cfg_we = 1'b0;
      sh_b[ad] = d;
   endtask

   // One run on instance A; pushes the expected result, returns observations.
   task automatic run_a(input logic [15:0] x0, input logic [15:0] x1,
                        input bit wr, input logic [1:0] wa, input logic [15:0] wd,
                        input bit scramble, input bit fire_in_done,
                        output int edges, output int busyc, output logic [15:0] dout,
                        output logic ovf, output logic done_after, output logic busy_after);
      logic [15:0] xs [4];
      logic [15:0] ws [4];
      if (wr && wa < 2'd3) sh_a[wa] = wd;
      xs = '{x0, x1, 16'h0, 16'h0};
      ws = '{sh_a[0], sh_a[1], 16'h0, 16'h0};
      q_a.push_back(model(xs, ws, sh_a[2], 2));
      a_if.data_in = {x1, x0};
      a_if.fire = 1'b1;
      if (wr) begin a_if.cfg_we = 1'b1; a_if.cfg_addr = wa; a_if.cfg_wdata = wd; end
      tick();
      a_if.fire = 1'b0; a_if.cfg_we = 1'b0;
      edges = 1;
      busyc = (a_if.busy === 1'b1) ? 1 : 0;
      if (scramble) a_if.data_in = $urandom();
      while (a_if.done !== 1'b1 && edges < 40) begin
         tick();
         edges++;
         if (a_if.busy === 1'b1) busyc++;
      end
      dout = a_if.data_out;
      ovf  = a_if.overflow;
      if (fire_in_done) a_if.fire = 1'b1;
      tick();
      a_if.fire = 1'b0;
      done_after = a_if.done;
      busy_after = a_if.busy;
   endtask

   // One run on instance B; optionally pokes fire and cfg_we mid-run.
   task automatic run_b(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2,
                        input bit inject, output int edges, output int busyc,
                        output logic [31:0] dout, output logic ovf, output logic done_after);
      logic [15:0] xs [4];
      logic [15:0] w0 [4];
      logic [15:0] w1 [4];
      logic [16:0] e0, e1;
      xs = '{x0, x1, x2, 16'h0};
      w0 = '{sh_b[0], sh_b[1], sh_b[2], 16'h0};
      w1 = '{sh_b[4], sh_b[5], sh_b[6], 16'h0};
      e0 = model(xs, w0, sh_b[3], 3);
      e1 = model(xs, w1, sh_b[7], 3);
      q_b.push_back({e0[16] | e1[16], e1[15:0], e0[15:0]});
      b_if.data_in = {x2, x1, x0};
      b_if.fire = 1'b1;
      tick();
      b_if.fire = 1'b0;
      edges = 1;
      busyc = (b_if.busy === 1'b1) ? 1 : 0;
      while (b_if.done !== 1'b1 && edges < 60) begin
         if (inject && edges == 3) begin
            b_if.fire = 1'b1; b_if.cfg_we = 1'b1; b_if.cfg_addr = 3'd0; b_if.cfg_wdata = 16'h1111;
         end else begin
            b_if.fire = 1'b0; b_if.cfg_we = 1'b0;
         end
         tick();
         edges++;
         if (b_if.busy === 1'b1) busyc++;
      end
      b_if.fire = 1'b0; b_if.cfg_we = 1'b0;
      dout = b_if.data_out;
      ovf  = b_if.overflow;
      tick();
      done_after = b_if.done;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (a_if.data_out !== 16'h0) begin n_miss++; $display("FAIL reset_a_dout: got %h expected 0000", a_if.data_out); end
      n_vec++; if (a_if.busy !== 1'b0) begin n_miss++; $display("FAIL reset_a_busy: got %b expected 0", a_if.busy); end
      n_vec++; if (a_if.done !== 1'b0) begin n_miss++; $display("FAIL reset_a_done: got %b expected 0", a_if.done); end
      n_vec++; if (a_if.overflow !== 1'b0) begin n_miss++; $display("FAIL reset_a_ovf: got %b expected 0", a_if.overflow); end
      n_vec++; if (b_if.data_out !== 32'h0) begin n_miss++; $display("FAIL reset_b_dout: got %h expected 0", b_if.data_out); end
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) sh_a[k] = 16'h0;
      for (int k = 0; k < 8; k++) sh_b[k] = 16'h0;
   endtask

   task automatic test_basic();
      int e, bc; logic [15:0] d; logic o, da, ba; logic [16:0] ex;
      cfg_a(2'd0, 16'h2000); cfg_a(2'd1, 16'h2000); cfg_a(2'd2, 16'h0000);
      run_a(16'h1000, 16'h0800, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, e, bc, d, o, da, ba);
      ex = q_a.pop_front();
      n_vec++; if (d !== ex[15:0]) begin n_miss++; $display("FAIL basic_dout: got %h expected %h", d, ex[15:0]); end
      n_vec++; if (d !== 16'h1800) begin n_miss++; $display("FAIL basic_dout_const: got %h expected 1800", d); end
      n_vec++; if (o !== ex[16]) begin n_miss++; $display("FAIL basic_ovf: got %b expected %b", o, ex[16]); end
      n_vec++; if (e !== 4) begin n_miss++; $display("FAIL basic_latency: got %0d expected 4", e); end
      n_vec++; if (bc !== 4) begin n_miss++; $display("FAIL basic_busy_cycles: got %0d expected 4", bc); end
      n_vec++; if (da !== 1'b0) begin n_miss++; $display("FAIL basic_done_width: got %b expected 0", da); end
      n_vec++; if (ba !== 1'b0) begin n_miss++; $display("FAIL basic_busy_after: got %b expected 0", ba); end
   endtask

   task automatic test_saturation();
      int e, bc; logic [15:0] d; logic o, da, ba; logic [16:0] ex;
      cfg_a(2'd0, 16'h7FFF); cfg_a(2'd1, 16'h7FFF); cfg_a(2'd2, 16'h7FFF);
      run_a(16'h7FFF, 16'h7FFF, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, e, bc, d, o, da, ba);
      ex = q_a.pop_front();
      n_vec++; if (d !== ex[15:0]) begin n_miss++; $display("FAIL sat_dout: got %h expected %h", d, ex[15:0]); end
      n_vec++; if (o !== 1'b1) begin n_miss++; $display("FAIL sat_ovf: got %b expected 1", o); end
      cfg_a(2'd2, 16'h0000);
      run_a(16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, e, bc, d, o, da, ba);
      ex = q_a.pop_front();
      n_vec++; if (d !== ex[15:0]) begin n_miss++; $display("FAIL sat_clear_dout: got %h expected %h", d, ex[15:0]); end
      n_vec++; if (o !== 1'b0) begin n_miss++; $display("FAIL sat_clear_ovf: got %b expected 0", o); end
   endtask

   task automatic test_negative();
      int e, bc; logic [15:0] d; logic o, da, ba; logic [16:0] ex; logic [15:0] want;
`ifdef DENSE_LAYER_RELU_EN
      want = 16'h0000;
`else
      want = 16'hE000;
`endif
      cfg_a(2'd0, 16'hE000); cfg_a(2'd1, 16'h0000); cfg_a(2'd2, 16'h0000);
      run_a(16'h2000, 16'h0000, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, e, bc, d, o, da, ba);
      ex = q_a.pop_front();
      n_vec++; if (d !== ex[15:0]) begin n_miss++; $display("FAIL neg_dout: got %h expected %h", d, ex[15:0]); end
      n_vec++; if (d !== want) begin n_miss++; $display("FAIL neg_dout_const: got %h expected %h", d, want); end
      n_vec++; if (o !== 1'b0) begin n_miss++; $display("FAIL neg_ovf: got %b expected 0", o); end
   endtask

   task automatic test_cfg_with_fire();
      int e, bc; logic [15:0] d; logic o, da, ba; logic [16:0] ex;
      cfg_a(2'd0, 16'h2000); cfg_a(2'd1, 16'h2000); cfg_a(2'd2, 16'h0000);
      run_a(16'h1000, 16'h0800, 1'b1, 2'd2, 16'h1000, 1'b0, 1'b0, e, bc, d, o, da, ba);
      ex = q_a.pop_front();
      n_vec++; if (d !== ex[15:0]) begin n_miss++; $display("FAIL cfg_fire_dout: got %h expected %h", d, ex[15:0]); end
      n_vec++; if (d !== 16'h2800) begin n_miss++; $display("FAIL cfg_fire_dout_const: got %h expected 2800", d); end
   endtask

   task automatic test_back_to_back();
      int e, bc; logic [15:0] d; logic o, da, ba; logic [16:0] ex;
      run_a(16'h1000, 16'h0800, 1'b0, 2'd0, 16'h0, 1'b1, 1'b1, e, bc, d, o, da, ba);
      ex = q_a.pop_front();
      n_vec++; if (d !== ex[15:0]) begin n_miss++; $display("FAIL b2b_scramble_dout: got %h expected %h", d, ex[15:0]); end
      n_vec++; if (ba !== 1'b0) begin n_miss++; $display("FAIL b2b_fire_in_done_busy: got %b expected 0", ba); end
      run_a(16'hF000, 16'h0400, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, e, bc, d, o, da, ba);
      ex = q_a.pop_front();
      n_vec++; if (d !== ex[15:0]) begin n_miss++; $display("FAIL b2b_second_dout: got %h expected %h", d, ex[15:0]); end
      n_vec++; if (e !== 4) begin n_miss++; $display("FAIL b2b_second_latency: got %0d expected 4", e); end
   endtask

   task automatic test_out_of_range();
      int e, bc; logic [15:0] d; logic o, da, ba; logic [16:0] ex;
      cfg_a(2'd0, 16'h2000); cfg_a(2'd1, 16'h2000); cfg_a(2'd2, 16'h0000);
      cfg_a(2'd3, 16'h1234);
      run_a(16'h1000, 16'h0800, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, e, bc, d, o, da, ba);
      ex = q_a.pop_front();
      n_vec++; if (d !== ex[15:0]) begin n_miss++; $display("FAIL oor_dout: got %h expected %h", d, ex[15:0]); end
      n_vec++; if (d !== 16'h1800) begin n_miss++; $display("FAIL oor_dout_const: got %h expected 1800", d); end
   endtask

   task automatic test_multi_neuron();
      int e, bc; logic [31:0] d; logic o, da; logic [32:0] ex;
      logic [15:0] cv [8];
      cv = '{16'h2000, 16'h1000, 16'hF000, 16'h0400, 16'h4000, 16'h2000, 16'h6000, 16'hF000};
      for (int k = 0; k < 8; k++) cfg_b(3'(k), cv[k]);
      run_b(16'h1000, 16'h2000, 16'h0800, 1'b0, e, bc, d, o, da);
      ex = q_b.pop_front();
      n_vec++; if (d !== ex[31:0]) begin n_miss++; $display("FAIL multi_dout: got %h expected %h", d, ex[31:0]); end
      n_vec++; if (o !== ex[32]) begin n_miss++; $display("FAIL multi_ovf: got %b expected %b", o, ex[32]); end
      n_vec++; if (e !== 9) begin n_miss++; $display("FAIL multi_latency: got %0d expected 9", e); end
      n_vec++; if (bc !== 9) begin n_miss++; $display("FAIL multi_busy_cycles: got %0d expected 9", bc); end
      n_vec++; if (da !== 1'b0) begin n_miss++; $display("FAIL multi_done_width: got %b expected 0", da); end
      run_b(16'h1000, 16'h2000, 16'h0800, 1'b1, e, bc, d, o, da);
      ex = q_b.pop_front();
      n_vec++; if (d !== ex[31:0]) begin n_miss++; $display("FAIL multi_inject_dout: got %h expected %h", d, ex[31:0]); end
      n_vec++; if (e !== 9) begin n_miss++; $display("FAIL multi_inject_latency: got %0d expected 9", e); end
      run_b(16'h6000, 16'hC000, 16'h7000, 1'b0, e, bc, d, o, da);
      ex = q_b.pop_front();
      n_vec++; if (d !== ex[31:0]) begin n_miss++; $display("FAIL multi_after_inject_dout: got %h expected %h", d, ex[31:0]); end
      n_vec++; if (o !== ex[32]) begin n_miss++; $display("FAIL multi_after_inject_ovf: got %b expected %b", o, ex[32]); end
   endtask

   task automatic test_reset_mid_run();
      int e, bc; logic [15:0] d; logic o, da, ba; logic [16:0] ex; logic seen;
      logic [31:0] db; logic ob, dab; logic [32:0] exb;
      a_if.data_in = {16'h0800, 16'h1000};
      a_if.fire = 1'b1;
      tick();
      a_if.fire = 1'b0;
      tick();
      #2 rstn = 1'b0;
      #1;
      n_vec++; if (a_if.data_out !== 16'h0) begin n_miss++; $display("FAIL midrst_a_dout: got %h expected 0000", a_if.data_out); end
      n_vec++; if (a_if.busy !== 1'b0) begin n_miss++; $display("FAIL midrst_a_busy: got %b expected 0", a_if.busy); end
      n_vec++; if (b_if.data_out !== 32'h0) begin n_miss++; $display("FAIL midrst_b_dout: got %h expected 0", b_if.data_out); end
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (a_if.done !== 1'b0) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_miss++; $display("FAIL midrst_no_done: got %b expected 0", seen); end
      rstn = 1'b1;
      for (int k = 0; k < 3; k++) sh_a[k] = 16'h0;
      for (int k = 0; k < 8; k++) sh_b[k] = 16'h0;
      run_a(16'h1234, 16'h2345, 1'b0, 2'd0, 16'h0, 1'b0, 1'b0, e, bc, d, o, da, ba);
      ex = q_a.pop_front();
      n_vec++; if (e !== 4) begin n_miss++; $display("FAIL midrst_first_fire_latency: got %0d expected 4", e); end
      n_vec++; if (d !== ex[15:0]) begin n_miss++; $display("FAIL midrst_coef_cleared: got %h expected %h", d, ex[15:0]); end
      run_b(16'h1000, 16'h2000, 16'h0800, 1'b0, e, bc, db, ob, dab);
      exb = q_b.pop_front();
      n_vec++; if (db !== exb[31:0]) begin n_miss++; $display("FAIL midrst_b_coef_cleared: got %h expected %h", db, exb[31:0]); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      tick();
      test_basic();
      test_saturation();
      test_negative();
      test_cfg_with_fire();
      test_back_to_back();
      test_out_of_range();
      test_multi_neuron();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
